systolic_mm_array: RTL
======================

Name: systolic_mm_array

Overview:
- Parametrised output-stationary systolic matrix-multiply array, ROWS x COLS processing cells; next generation of the fixed 4x4 linear PE array.
- Computes C[ROWS][COLS] = A[ROWS][K] x W[K][COLS] over a runtime K streamed one k-slice per beat.
- Adds internal input skewing, per-operand valid propagation (stall tolerance), an optional saturating mode and a row-serial result drain with ready/valid backpressure.
- Sits between the operand buffers and the result writeback in the accelerator datapath.

Parameters:
- ROWS, 4, number of array rows (activation lanes), >=1
- COLS, 4, number of array columns (weight lanes), >=1
- DATA_W, 8, signed operand width
- ACC_W, 24, signed accumulator and result width, >= 2*DATA_W
- K_W, 10, width of k_len; max K = 2^K_W-1
- SAT, 0, 0 = accumulate modulo 2^ACC_W, 1 = saturate to signed ACC_W range

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- k_len  in  K_W  number of k-slices; sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepts operand beat
- in_a  in  ROWS x DATA_W  A[r][k] for all r, one k per beat
- in_w  in  COLS x DATA_W  W[k][c] for all c, same k
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts result row
- out_row  out  COLS x ACC_W  C[out_idx][0..COLS-1]
- out_idx  out  $clog2(ROWS) (min 1)  row index of out_row
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset: state IDLE; accumulators, skew regs, counters zero; in_ready, out_valid, busy, done = 0; out_row, out_idx = 0. Asynchronous assertion, synchronous-safe deassertion not handled here.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: start=1 -> clear all accumulators, latch k_len, go LOAD; if k_len==0, go FLUSH directly (all results 0). start outside IDLE ignored.
- LOAD: in_ready=1. Beat accepted when in_valid&&in_ready; beat counter increments; accepting beat k_len-1 -> FLUSH next cycle. in_valid=0 injects bubble (valid=0), no accumulate.
- Skew: lane r of in_a delayed r cycles, lane c of in_w delayed c cycles, each with valid bit. Cell (r,c) registers a/w/valid to right/down neighbours every cycle; accumulates a*w only when both incoming valids=1 (always coincident by construction).
- Product: full signed 2*DATA_W, sign-extended to ACC_W. SAT=1: clamp on overflow to +2^(ACC_W-1)-1 / -2^(ACC_W-1); SAT=0: wrap.
- FLUSH: in_ready=0, zero/invalid injected; lasts exactly ROWS+COLS-1 cycles, then DRAIN. First out_valid therefore ROWS+COLS cycles after last accepted beat.
- DRAIN: out_valid=1, out_row = accumulators of row out_idx, out_idx starts 0. On out_valid&&out_ready: out_idx++; after row ROWS-1 accepted -> IDLE, done=1 for that next cycle. out_row/out_idx stable while out_valid && !out_ready.
- Reset mid-job: job discarded, all state to reset values; no done.
- in_ready is 0 in IDLE, FLUSH, DRAIN; beats presented there are not consumed.

Decomposition:
- Package systolic_pkg: state enum, sat_add function (ACC_W-generic via parameters or localparam bounds), default parameter constants.
- Sub-module pe_cell: one MAC cell (a/w/valid pass-through registers, accumulator, clear, SAT option); array generated as ROWS x COLS grid in the top.

Test Plan:
- 4x4, K=1, A col=[1,2,3,4], W row=[1,1,1,1] -> rows C[r]=[r+1 x4]; first out_valid 8 cycles after beat; done pulse after row 3.
- 4x4, K=4, A=identity, W=[[1..4],[5..8],[9..12],[13..16]] -> C==W; out_ready held high, 4 consecutive rows, out_idx 0..3.
- Same job with in_valid toggling 1/0 and out_ready low 3 cycles on row 2 -> identical results, out_row/out_idx stable during stall.
- SAT=1, ACC_W=16, K=3, all operands -128 x -128 -> 49152 overflows -> every C = 32767; SAT=0 same stimulus -> 49152 mod 2^16 signed = -16384.
- k_len=0 start -> no in_ready, FLUSH 7 cycles, 4 rows of zeros, done.
- rstn low during LOAD after 2 beats -> all outputs 0 immediately; new job afterwards gives correct results (no stale accumulation); ROWS=2,COLS=3 K=2 random signed vs model.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types, default sizes and the accumulate/saturate helper for the
// output-stationary systolic matrix-multiply array.
package systolic_pkg;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_K_W    = 10;
    localparam int DEF_SAT    = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Add in a wide domain, then either clamp to or wrap into a signed acc_w range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int acc_w,
                                                   input logic sat);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sat)
            return (sum > hi) ? hi : ((sum < lo) ? lo : sum);
        return (sum <<< (64 - acc_w)) >>> (64 - acc_w);
    endfunction

endpackage

// File: rtl/systolic_mm_array_pe_cell.sv
// One multiply-accumulate cell: forwards a right and w down every cycle and
// accumulates a*w when both operand valids arrive together.
module pe_cell
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SAT    = DEF_SAT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_w,
    input  logic              i_a_valid,
    input  logic              i_w_valid,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_w,
    output logic              o_a_valid,
    output logic              o_w_valid,
    output logic [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod = $signed(i_a) * $signed(i_w);
    assign o_acc  = r_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= '0;
            o_a       <= '0;
            o_w       <= '0;
            o_a_valid <= 1'b0;
            o_w_valid <= 1'b0;
        end else begin
            o_a       <= i_a;
            o_w       <= i_w;
            o_a_valid <= i_a_valid;
            o_w_valid <= i_w_valid;
            if (i_clear)
                r_acc <= '0;
            else if (i_a_valid && i_w_valid)
                r_acc <= ACC_W'(sat_add(64'(r_acc), 64'(w_prod), ACC_W, SAT != 0));
        end
    end

endmodule

// File: rtl/systolic_mm_array.sv
// ROWS x COLS output-stationary systolic array with input skewing, a flush
// phase and a row-serial ready/valid result drain.
module systolic_mm_array
    import systolic_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int K_W    = DEF_K_W,
    parameter int SAT    = DEF_SAT,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_a,
    input  logic [COLS*DATA_W-1:0] in_w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_row,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    localparam int FL_W = $clog2(ROWS + COLS) + 1;

    state_t            r_state, w_next;
    logic [K_W-1:0]    r_k_len, r_beat_cnt;
    logic [FL_W-1:0]   r_flush_cnt;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_done;
    logic              w_accept, w_clear, w_last_row;

    logic [DATA_W-1:0] w_a  [ROWS][COLS+1];
    logic              w_av [ROWS][COLS+1];
    logic [DATA_W-1:0] w_w  [ROWS+1][COLS];
    logic              w_wv [ROWS+1][COLS];
    logic [ACC_W-1:0]  w_acc [ROWS][COLS];

    assign w_accept   = in_valid && in_ready;
    assign w_clear    = (r_state == S_IDLE) && start;
    assign w_last_row = (r_out_idx == IDX_W'(ROWS - 1));
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign out_idx    = r_out_idx;
    assign dbg_state  = r_state;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = (k_len == '0) ? S_FLUSH : S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_beat_cnt == r_k_len - 1'b1)) w_next = S_FLUSH;
            end
            S_FLUSH: if (r_flush_cnt == FL_W'(ROWS + COLS - 2)) w_next = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_last_row) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= (r_state == S_DRAIN) && out_ready && w_last_row;
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
            if (w_clear) begin
                r_k_len    <= k_len;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (out_valid && out_ready)
                r_out_idx <= w_last_row ? '0 : r_out_idx + 1'b1;
        end
    end

    // Lane r of A enters r cycles late, lane c of W c cycles late, so the
    // k-th operands meet in cell (r,c) exactly r+c cycles after acceptance.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_W-1:0] w_lane;
        assign w_lane = w_accept ? in_a[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign w_a[0][0]  = w_lane;
            assign w_av[0][0] = w_accept;
        end else begin : g_delay
            logic [DATA_W-1:0] r_d [r];
            logic              r_v [r];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < r; i++) begin
                        r_d[i] <= '0;
                        r_v[i] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= w_lane;
                    r_v[0] <= w_accept;
                    for (int i = 1; i < r; i++) begin
                        r_d[i] <= r_d[i-1];
                        r_v[i] <= r_v[i-1];
                    end
                end
            end
            assign w_a[r][0]  = r_d[r-1];
            assign w_av[r][0] = r_v[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w_skew
        logic [DATA_W-1:0] w_lane;
        assign w_lane = w_accept ? in_w[c*DATA_W +: DATA_W] : '0;
        if (c == 0) begin : g_direct
            assign w_w[0][0]  = w_lane;
            assign w_wv[0][0] = w_accept;
        end else begin : g_delay
            logic [DATA_W-1:0] r_d [c];
            logic              r_v [c];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < c; i++) begin
                        r_d[i] <= '0;
                        r_v[i] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= w_lane;
                    r_v[0] <= w_accept;
                    for (int i = 1; i < c; i++) begin
                        r_d[i] <= r_d[i-1];
                        r_v[i] <= r_v[i-1];
                    end
                end
            end
            assign w_w[0][c]  = r_d[c-1];
            assign w_wv[0][c] = r_v[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_cell #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SAT    (SAT)
            ) u_pe (
                .clk       (clk),
                .rstn      (rstn),
                .i_clear   (w_clear),
                .i_a       (w_a[r][c]),
                .i_w       (w_w[r][c]),
                .i_a_valid (w_av[r][c]),
                .i_w_valid (w_wv[r][c]),
                .o_a       (w_a[r][c+1]),
                .o_w       (w_w[r+1][c]),
                .o_a_valid (w_av[r][c+1]),
                .o_w_valid (w_wv[r+1][c]),
                .o_acc     (w_acc[r][c])
            );
        end
    end

    always_comb begin
        out_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_out_idx == IDX_W'(r)) begin
                for (int c = 0; c < COLS; c++)
                    out_row[c*ACC_W +: ACC_W] = w_acc[r][c];
            end
        end
    end

endmodule
